mult_dispatch: RTL

Issue/writeback controller between the ID-stage decoder and the integer multiplier (cv32e40p_mult).
- Upstream: accepts one decoded M-extension multiply (mul/mulh/mulhsu/mulhu) with operands and destination tag over a valid/ready handshake.
- Multiplier side: maps the instruction to operator/signed-mode, holds operands stable and drives enable until the multiplier reports ready.
- Downstream: captures the result and presents it to writeback over a second valid/ready handshake.
- Also handles pipeline kill and a hang watchdog.

---
 rtl/mult_dispatch_pkg.sv | 46 ++++
 rtl/mult_dispatch.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mult_dispatch_pkg.sv
// Shared types for the multiply issue/writeback controller: multiplier opcodes,
// funct3 and signed-mode encodings, FSM states and the funct3 decode helper.
package mult_pkg;

  localparam int MUL_OP_WIDTH = 3;

  typedef enum logic [MUL_OP_WIDTH-1:0] {
    MUL_MAC32 = 3'b000,
    MUL_H     = 3'b110
  } mul_opcode_e;

  localparam logic [1:0] F3_MUL    = 2'b00;
  localparam logic [1:0] F3_MULH   = 2'b01;
  localparam logic [1:0] F3_MULHSU = 2'b10;
  localparam logic [1:0] F3_MULHU  = 2'b11;

  // bit 0 marks op_a signed, bit 1 marks op_b signed
  localparam logic [1:0] SM_SS = 2'b11;
  localparam logic [1:0] SM_SU = 2'b01;
  localparam logic [1:0] SM_UU = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } md_state_e;

  typedef struct packed {
    mul_opcode_e op;
    logic [1:0]  sm;
  } mul_ctrl_t;

  function automatic mul_ctrl_t decode_funct3(input logic [1:0] f3);
    mul_ctrl_t c;
    c.op = MUL_H;
    c.sm = SM_UU;
    case (f3)
      F3_MUL:    begin c.op = MUL_MAC32; c.sm = SM_UU; end
      F3_MULH:   begin c.op = MUL_H;     c.sm = SM_SS; end
      F3_MULHSU: begin c.op = MUL_H;     c.sm = SM_SU; end
      default:   begin c.op = MUL_H;     c.sm = SM_UU; end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mult_dispatch.sv
// Issue/writeback controller between the ID-stage decoder and the integer
// multiplier: latches one multiply, holds it on the multiplier, hands the result on.
//
// state    | meaning
// ST_IDLE  | waiting for a decoded multiply (dec_ready_o = !kill_i)
// ST_ISSUE | operands held, mult_en_o high, watchdog running
// ST_RESP  | result presented to writeback until wb_ready_i or kill_i
module mult_dispatch
  import mult_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int DW             = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dec_valid_i,
  output logic          dec_ready_o,
  input  logic [1:0]    dec_funct3_i,
  input  logic [DW-1:0] dec_op_a_i,
  input  logic [DW-1:0] dec_op_b_i,
  input  logic [4:0]    dec_rd_i,
  input  logic          kill_i,
  output logic          mult_en_o,
  output logic [2:0]    mult_operator_o,
  output logic [1:0]    mult_signed_o,
  output logic [DW-1:0] mult_op_a_o,
  output logic [DW-1:0] mult_op_b_o,
  output logic          mult_ex_ready_o,
  input  logic [DW-1:0] mult_result_i,
  input  logic          mult_ready_i,
  output logic          wb_valid_o,
  input  logic          wb_ready_i,
  output logic [4:0]    wb_rd_o,
  output logic [DW-1:0] wb_data_o,
  output logic          err_timeout_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  md_state_e     state;
  mul_ctrl_t     ctrl_q;
  logic [4:0]    rd_q;
  logic [CW-1:0] wd_cnt;
  logic          killed;
  logic          idle_q;
  logic          accept;
  logic          wd_expire;

  // idle_q mirrors ST_IDLE but is 0 in reset so dec_ready_o is low then too
  assign dec_ready_o     = idle_q & ~kill_i;
  assign accept          = dec_valid_i & dec_ready_o;
  assign mult_ex_ready_o = (state == ST_ISSUE) & mult_ready_i;
  assign wd_expire       = (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign mult_operator_o = ctrl_q.op;
  assign mult_signed_o   = ctrl_q.sm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      idle_q        <= 1'b0;
      ctrl_q        <= '0;
      rd_q          <= '0;
      wd_cnt        <= '0;
      killed        <= 1'b0;
      mult_en_o     <= 1'b0;
      mult_op_a_o   <= '0;
      mult_op_b_o   <= '0;
      wb_valid_o    <= 1'b0;
      wb_rd_o       <= '0;
      wb_data_o     <= '0;
      err_timeout_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          idle_q <= 1'b1;
          killed <= 1'b0;
          if (accept) begin
            mult_op_a_o <= dec_op_a_i;
            mult_op_b_o <= dec_op_b_i;
            ctrl_q      <= decode_funct3(dec_funct3_i);
            rd_q        <= dec_rd_i;
            wd_cnt      <= '0;
            mult_en_o   <= 1'b1;
            idle_q      <= 1'b0;
            state       <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (mult_ready_i) begin
            mult_en_o <= 1'b0;
            wb_data_o <= mult_result_i;
            wb_rd_o   <= rd_q;
            // a kill seen in any ISSUE cycle, including this one, drops the result
            if (killed || kill_i) begin
              killed <= 1'b0;
              idle_q <= 1'b1;
              state  <= ST_IDLE;
            end else begin
              wb_valid_o <= 1'b1;
              state      <= ST_RESP;
            end
          end else if (wd_expire) begin
            err_timeout_o <= 1'b1;
            mult_en_o     <= 1'b0;
            killed        <= 1'b0;
            idle_q        <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
            if (kill_i) killed <= 1'b1;
          end
        end

        ST_RESP: begin
          if (kill_i || wb_ready_i) begin
            wb_valid_o <= 1'b0;
            idle_q     <= 1'b1;
            state      <= ST_IDLE;
          end
        end

        default: begin
          mult_en_o  <= 1'b0;
          wb_valid_o <= 1'b0;
          killed     <= 1'b0;
          idle_q     <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
